// File: rtl/stage_if.sv
// LC-3b instruction-fetch stage: fetch PC, icache handshake and IF/ID register.
// A one-entry hold buffer absorbs a response that lands during a stall.
module stage_if #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_target,
  input  logic        icache_resp,
  input  logic [15:0] icache_rdata,
  output logic        icache_read,
  output logic [15:0] icache_address,
  output logic [15:0] ir_out,
  output logic [15:0] pc_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DROP
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] fetch_pc, fetch_pc_nxt;
  logic [15:0] pending_pc, pending_pc_nxt;
  logic [15:0] hold_ir, hold_ir_nxt;
  logic [15:0] target;
  logic [15:0] pc_inc;
  logic        deliver;
  logic [15:0] deliver_ir;

  assign target         = {redirect_target[15:1], 1'b0};
  assign pc_inc         = fetch_pc + 16'd2;
  assign icache_read    = (state != HOLD);
  assign icache_address = fetch_pc;

  always_comb begin
    state_nxt      = state;
    fetch_pc_nxt   = fetch_pc;
    pending_pc_nxt = pending_pc;
    hold_ir_nxt    = hold_ir;
    deliver        = 1'b0;
    deliver_ir     = 16'h0000;
    unique case (state)
      FETCH: begin
        if (icache_resp) begin
          if (redirect) begin
            fetch_pc_nxt = target;
          end else if (!stall) begin
            deliver      = 1'b1;
            deliver_ir   = icache_rdata;
            fetch_pc_nxt = pc_inc;
          end else begin
            hold_ir_nxt = icache_rdata;
            state_nxt   = HOLD;
          end
        end else if (redirect) begin
          pending_pc_nxt = target;
          state_nxt      = DROP;
        end
      end
      HOLD: begin
        if (redirect) begin
          fetch_pc_nxt = target;
          state_nxt    = FETCH;
        end else if (!stall) begin
          deliver      = 1'b1;
          deliver_ir   = hold_ir;
          fetch_pc_nxt = pc_inc;
          state_nxt    = FETCH;
        end
      end
      DROP: begin
        if (redirect) pending_pc_nxt = target;
        // wrong-path response retires; newest redirect wins
        if (icache_resp) begin
          fetch_pc_nxt = redirect ? target : pending_pc;
          state_nxt    = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= FETCH;
      fetch_pc   <= RESET_PC;
      pending_pc <= 16'h0000;
      hold_ir    <= 16'h0000;
    end else begin
      state      <= state_nxt;
      fetch_pc   <= fetch_pc_nxt;
      pending_pc <= pending_pc_nxt;
      hold_ir    <= hold_ir_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_out    <= 16'h0000;
      pc_out    <= 16'h0000;
      valid_out <= 1'b0;
    end else if (redirect) begin
      ir_out    <= 16'h0000;
      valid_out <= 1'b0;
    end else if (!stall) begin
      if (deliver) begin
        ir_out    <= deliver_ir;
        pc_out    <= pc_inc;
        valid_out <= 1'b1;
      end else begin
        ir_out    <= 16'h0000;
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: directed vector table, hand-written corner cases
// and randomized traffic against a behavioural fetch model.
module tb_stage_if;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_target;
  logic        icache_resp;
  logic [15:0] icache_rdata;
  logic        icache_read;
  logic [15:0] icache_address;
  logic [15:0] ir_out;
  logic [15:0] pc_out;
  logic        valid_out;

  int n_checks = 0;
  int n_errors = 0;

  stage_if #(.RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .icache_resp    (icache_resp),
    .icache_rdata   (icache_rdata),
    .icache_read    (icache_read),
    .icache_address (icache_address),
    .ir_out         (ir_out),
    .pc_out         (pc_out),
    .valid_out      (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [15:0] tgt;
    logic        resp;
    logic [15:0] rdata;
    logic        e_read;
    logic [15:0] e_addr;
    logic [15:0] e_ir;
    logic [15:0] e_pc;
    logic        e_valid;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_read,
                           input logic [15:0] e_addr, input logic [15:0] e_ir,
                           input logic [15:0] e_pc, input logic e_valid);
    chk({tag, " read"}, {15'h0, icache_read}, {15'h0, e_read});
    chk({tag, " addr"}, icache_address, e_addr);
    chk({tag, " ir"}, ir_out, e_ir);
    chk({tag, " pc"}, pc_out, e_pc);
    chk({tag, " valid"}, {15'h0, valid_out}, {15'h0, e_valid});
  endtask

  // Drive one cycle at a negedge, return at the following negedge.
  task automatic step(input logic s, input logic r, input logic [15:0] t,
                      input logic rsp, input logic [15:0] d);
    stall           = s;
    redirect        = r;
    redirect_target = t;
    icache_resp     = rsp;
    icache_rdata    = d;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(0, 0, 16'h0, 0, 16'h0);
    step(0, 0, 16'h0, 0, 16'h0);
    reset_n = 1'b1;
  endtask

  // Behavioural model: a PC, an optional wrong-path flag and a 0/1 deep
  // queue of instructions waiting for the stall to clear.
  logic [15:0] m_pc, m_pend, m_ir, m_pcout;
  logic        m_v, m_wrong;
  logic [15:0] m_hold[$];

  task automatic model_reset();
    m_pc = 16'h0000; m_pend = 16'h0; m_ir = 16'h0;
    m_pcout = 16'h0; m_v = 1'b0; m_wrong = 1'b0;
    m_hold.delete();
  endtask

  task automatic model_step(input logic s, input logic r, input logic [15:0] t,
                            input logic rsp, input logic [15:0] d);
    logic        outst;
    logic        has;
    logic [15:0] w;
    outst = (m_hold.size() == 0);
    has = 1'b0;
    w = 16'h0;
    if (r) begin
      m_ir = 16'h0;
      m_v  = 1'b0;
      if (outst && !rsp) begin
        m_wrong = 1'b1;
        m_pend  = t & 16'hFFFE;
      end else begin
        m_pc    = t & 16'hFFFE;
        m_wrong = 1'b0;
        m_hold.delete();
      end
    end else if (m_wrong) begin
      if (rsp) begin
        m_pc    = m_pend;
        m_wrong = 1'b0;
      end
      if (!s) begin
        m_ir = 16'h0;
        m_v  = 1'b0;
      end
    end else begin
      if (m_hold.size() != 0) begin
        has = 1'b1;
        w   = m_hold[0];
      end else if (rsp) begin
        has = 1'b1;
        w   = d;
      end
      if (s) begin
        if (outst && rsp) m_hold.push_back(d);
      end else if (has) begin
        m_ir    = w;
        m_pcout = m_pc + 16'd2;
        m_v     = 1'b1;
        m_pc    = m_pc + 16'd2;
        m_hold.delete();
      end else begin
        m_ir = 16'h0;
        m_v  = 1'b0;
      end
    end
  endtask

  initial begin
    logic        s, r, rsp;
    logic [15:0] t, d;
    stall = 0; redirect = 0; redirect_target = 0;
    icache_resp = 0; icache_rdata = 0;

    //            stl rdr tgt       rsp rdata     rd addr      ir        pc        v
    tbl[0]  = '{0, 0, 16'h0000, 1, 16'h1111, 1, 16'h0002, 16'h1111, 16'h0002, 1};
    tbl[1]  = '{0, 0, 16'h0000, 1, 16'h2222, 1, 16'h0004, 16'h2222, 16'h0004, 1};
    tbl[2]  = '{0, 0, 16'h0000, 1, 16'h3333, 1, 16'h0006, 16'h3333, 16'h0006, 1};
    tbl[3]  = '{0, 1, 16'h0010, 1, 16'hDEAD, 1, 16'h0010, 16'h0000, 16'h0006, 0};
    tbl[4]  = '{1, 0, 16'h0000, 1, 16'h1234, 0, 16'h0010, 16'h0000, 16'h0006, 0};
    tbl[5]  = '{1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0010, 16'h0000, 16'h0006, 0};
    tbl[6]  = '{1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0010, 16'h0000, 16'h0006, 0};
    tbl[7]  = '{0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0012, 16'h1234, 16'h0012, 1};
    tbl[8]  = '{0, 1, 16'hFFFF, 1, 16'hBEEF, 1, 16'hFFFE, 16'h0000, 16'h0012, 0};
    tbl[9]  = '{0, 0, 16'h0000, 1, 16'hABCD, 1, 16'h0000, 16'hABCD, 16'h0000, 1};
    tbl[10] = '{0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 0};
    tbl[11] = '{0, 0, 16'h0000, 1, 16'h5555, 1, 16'h0002, 16'h5555, 16'h0002, 1};
    tbl[12] = '{1, 1, 16'h0030, 0, 16'h0000, 1, 16'h0002, 16'h0000, 16'h0002, 0};
    tbl[13] = '{0, 0, 16'h0000, 1, 16'h6666, 1, 16'h0030, 16'h0000, 16'h0002, 0};

    do_reset();
    check_all("reset", 1, 16'h0000, 16'h0000, 16'h0000, 0);

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].stall, tbl[i].redir, tbl[i].tgt, tbl[i].resp, tbl[i].rdata);
      check_all($sformatf("vec%0d", i), tbl[i].e_read, tbl[i].e_addr,
                tbl[i].e_ir, tbl[i].e_pc, tbl[i].e_valid);
    end

    // redirect during a long miss: address holds, response dropped
    step(0, 1, 16'h0020, 1, 16'h0BAD);
    check_all("m3 setup", 1, 16'h0020, 16'h0000, 16'h0002, 0);
    step(0, 0, 16'h0000, 0, 16'h0000);
    check_all("m3 c1", 1, 16'h0020, 16'h0000, 16'h0002, 0);
    step(0, 1, 16'h0041, 0, 16'h0000);
    check_all("m3 c2", 1, 16'h0020, 16'h0000, 16'h0002, 0);
    step(0, 0, 16'h0000, 0, 16'h0000);
    step(0, 0, 16'h0000, 0, 16'h0000);
    check_all("m3 c4", 1, 16'h0020, 16'h0000, 16'h0002, 0);
    step(0, 0, 16'h0000, 1, 16'h7777);
    check_all("m3 resp", 1, 16'h0040, 16'h0000, 16'h0002, 0);
    step(0, 0, 16'h0000, 1, 16'h8888);
    check_all("m3 next", 1, 16'h0042, 16'h8888, 16'h0042, 1);

    // two redirects in one miss, second on the response cycle
    step(0, 1, 16'h0100, 0, 16'h0000);
    check_all("m4 r1", 1, 16'h0042, 16'h0000, 16'h0042, 0);
    step(0, 0, 16'h0000, 0, 16'h0000);
    step(0, 1, 16'h0200, 1, 16'hCCCC);
    check_all("m4 r2", 1, 16'h0200, 16'h0000, 16'h0042, 0);
    step(0, 0, 16'h0000, 1, 16'h9999);
    check_all("m4 next", 1, 16'h0202, 16'h9999, 16'h0202, 1);

    // asynchronous reset mid-miss
    step(0, 0, 16'h0000, 0, 16'h0000);
    #2 reset_n = 1'b0;
    #1 check_all("rst miss", 1, 16'h0000, 16'h0000, 16'h0000, 0);
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 0, 16'h0000, 1, 16'h4444);
    check_all("rst restart", 1, 16'h0002, 16'h4444, 16'h0002, 1);

    // asynchronous reset mid-HOLD
    step(1, 0, 16'h0000, 1, 16'h5555);
    check_all("hold", 0, 16'h0002, 16'h4444, 16'h0002, 1);
    #3 reset_n = 1'b0;
    #1 check_all("rst hold", 1, 16'h0000, 16'h0000, 16'h0000, 0);
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 0, 16'h0000, 1, 16'h6666);
    check_all("rst hold restart", 1, 16'h0002, 16'h6666, 16'h0002, 1);

    // randomized traffic against the model
    do_reset();
    model_reset();
    for (int i = 0; i < 2000; i++) begin
      s   = ($urandom_range(0, 3) == 0);
      r   = ($urandom_range(0, 7) == 0);
      t   = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom);
      rsp = (m_hold.size() == 0) && ($urandom_range(0, 1) == 1);
      d   = 16'($urandom);
      model_step(s, r, t, rsp, d);
      step(s, r, t, rsp, d);
      check_all($sformatf("rnd%0d", i), (m_hold.size() == 0), m_pc,
                m_ir, m_pcout, m_v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
